// File: rtl/fpd_result_fifo_if.sv
// Producer/consumer handshake bundle for fpd_result_fifo: divider results in, head entry out.
// The slave modport is the FIFO; the master modport is whatever drives and drains it.
interface fpd_result_fifo_if #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
);
  localparam int W = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] fpd_in;
  logic         overflow_in;
  logic         underflow_in;
  logic         dbz_in;
  logic         valid_out;
  logic         ready_in;
  logic [W-1:0] result_out;
  logic         overflow_out;
  logic         underflow_out;
  logic         dbz_out;

  modport slave (
    input  valid_in, fpd_in, overflow_in, underflow_in, dbz_in, ready_in,
    output ready_out, valid_out, result_out, overflow_out, underflow_out, dbz_out
  );

  modport master (
    output valid_in, fpd_in, overflow_in, underflow_in, dbz_in, ready_in,
    input  ready_out, valid_out, result_out, overflow_out, underflow_out, dbz_out
  );
endinterface

// File: rtl/fpd_result_fifo.sv
// DEPTH-entry result FIFO behind fp_divider with sticky exception status.
// Define FPD_EXC_COUNT_EN to add saturating per-flag exception counters.
module fpd_result_fifo #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  fpd_result_fifo_if.slave         bus,
  input  logic                     clear_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic [2:0]               exc_sticky_out
`ifdef FPD_EXC_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     ovf_cnt_out,
  output logic [CNT_WIDTH-1:0]     unf_cnt_out,
  output logic [CNT_WIDTH-1:0]     dbz_cnt_out
`endif
);

  localparam int W  = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int EW = W + 3;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic [2:0]    sticky_q, sticky_d;
  logic [2:0]    flags_in;
  logic [EW-1:0] head;
  logic          not_empty;
  logic          push;
  logic          pop;

  assign flags_in  = {bus.dbz_in, bus.underflow_in, bus.overflow_in};
  assign not_empty = (count_q != '0);
  assign push      = bus.valid_in & ready_q;
  assign pop       = not_empty & bus.ready_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    ready_d  = 1'b1;
    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      sticky_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        sticky_d = sticky_q | flags_in;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ready_d = (count_d != CW'(DEPTH));
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push && !clear_in) begin
      mem_d[wr_ptr_q] = {flags_in, bus.fpd_in};
    end
  end

  // Storage is deliberately left out of reset; only the bookkeeping is cleared.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      sticky_q <= sticky_d;
    end
  end

  assign head              = not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.valid_out     = not_empty;
  assign bus.ready_out     = ready_q;
  assign bus.result_out    = head[W-1:0];
  assign bus.overflow_out  = head[W];
  assign bus.underflow_out = head[W+1];
  assign bus.dbz_out       = head[W+2];
  assign count_out         = count_q;
  assign exc_sticky_out    = sticky_q;

`ifdef FPD_EXC_COUNT_EN
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_WIDTH-1:0] unf_cnt_q, unf_cnt_d;
  logic [CNT_WIDTH-1:0] dbz_cnt_q, dbz_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic hit);
    if (hit && (cnt != '1)) return cnt + CNT_WIDTH'(1);
    return cnt;
  endfunction

  always_comb begin
    ovf_cnt_d = '0;
    unf_cnt_d = '0;
    dbz_cnt_d = '0;
    if (!clear_in) begin
      ovf_cnt_d = sat_inc(ovf_cnt_q, push & flags_in[0]);
      unf_cnt_d = sat_inc(unf_cnt_q, push & flags_in[1]);
      dbz_cnt_d = sat_inc(dbz_cnt_q, push & flags_in[2]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
      dbz_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
      dbz_cnt_q <= dbz_cnt_d;
    end
  end

  assign ovf_cnt_out = ovf_cnt_q;
  assign unf_cnt_out = unf_cnt_q;
  assign dbz_cnt_out = dbz_cnt_q;
`endif

endmodule
